mux_wr_pipe: RTL

- Parametrised successor to the write-register destination mux.
- Each cycle, selects the destination register address from rt, sp, ra or rd, then carries it through a DEPTH-stage destination pipeline to writeback.
- Tracks all in-flight destinations and flags read-after-write hazards for the two source addresses being decoded.
- Sits between the control unit/decode and the register bank write port.

---
 rtl/mux_wr_pipe.sv | 109 ++++++++++
 1 files changed

// File: rtl/mux_wr_pipe.sv
// Write-register destination mux feeding a DEPTH-stage destination pipeline with RAW hazard detection.
// Optional saturating hazard counter on port hazard_cnt when MUX_WR_HAZARD_CNT_EN is defined.
module mux_wr_pipe #(
    parameter int unsigned           ADDR_W  = 5,
    parameter int unsigned           DEPTH   = 3,
    parameter logic [ADDR_W-1:0]     SP_ADDR = ADDR_W'(29),
    parameter logic [ADDR_W-1:0]     RA_ADDR = ADDR_W'(31)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Selector,
    input  logic [ADDR_W-1:0] rt_in,
    input  logic [ADDR_W-1:0] rd_in,
    input  logic              in_valid,
    input  logic              we_in,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs_q,
    input  logic [ADDR_W-1:0] rt_q,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              hazard_rs,
    output logic              hazard_rt
`ifdef MUX_WR_HAZARD_CNT_EN
    ,
    output logic [15:0]       hazard_cnt
`endif
);

    logic [DEPTH-1:0]  r_v;
    logic [DEPTH-1:0]  r_we;
    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic              w_cap_we;
    logic              w_hz_rs;
    logic              w_hz_rt;

    always_comb begin
        case (Selector)
            2'b00:   sel_addr = rt_in;
            2'b01:   sel_addr = SP_ADDR;
            2'b10:   sel_addr = RA_ADDR;
            default: sel_addr = rd_in;
        endcase
    end

    // Register 0 is hard-wired, so a write to it never reaches the bank.
    assign w_cap_we = we_in & (sel_addr != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v  <= '0;
            r_we <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
            end
        end else if (flush) begin
            r_v  <= '0;
            r_we <= '0;
        end else if (!stall) begin
            r_v[0]  <= in_valid;
            r_we[0] <= in_valid & w_cap_we;
            if (in_valid) begin
                r_addr[0] <= sel_addr;
            end
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_v[i]    <= r_v[i-1];
                r_we[i]   <= r_we[i-1];
                r_addr[i] <= r_addr[i-1];
            end
        end
    end

    assign wb_valid = r_v[DEPTH-1];
    assign wb_addr  = r_addr[DEPTH-1];
    // Gated by stall so a held last-stage entry writes the bank only once.
    assign wb_we    = r_v[DEPTH-1] & r_we[DEPTH-1] & ~stall;

    always_comb begin
        w_hz_rs = 1'b0;
        w_hz_rt = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_v[i] && r_we[i] && (r_addr[i] == rs_q)) begin
                w_hz_rs = 1'b1;
            end
            if (r_v[i] && r_we[i] && (r_addr[i] == rt_q)) begin
                w_hz_rt = 1'b1;
            end
        end
        hazard_rs = w_hz_rs & (rs_q != '0);
        hazard_rt = w_hz_rt & (rt_q != '0);
    end

`ifdef MUX_WR_HAZARD_CNT_EN
    logic [15:0] r_hz_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hz_cnt <= '0;
        end else if ((hazard_rs | hazard_rt) && !stall && (r_hz_cnt != '1)) begin
            r_hz_cnt <= r_hz_cnt + 16'd1;
        end
    end

    assign hazard_cnt = r_hz_cnt;
`endif

endmodule
